// File: rtl/button_press_classifier_pkg.sv
// Shared types and helpers for the button press classifier.
// Build option: BTN_AUTOREPEAT_EN enables auto-repeat in long hold.
package btn_pkg;

   typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} btn_state_t;

   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Button level in, classified events out.
// Build option: BTN_AUTOREPEAT_EN (repeat_o stays 0 when undefined).
interface button_press_classifier_if;
   logic btn_db;
   logic press_o;
   logic release_o;
   logic short_o;
   logic long_o;
   logic repeat_o;
   logic held_o;
   logic toggle_o;

   modport master (
      output btn_db,
      input  press_o, release_o, short_o, long_o,
      input  repeat_o, held_o, toggle_o
   );

   modport slave (
      input  btn_db,
      output press_o, release_o, short_o, long_o,
      output repeat_o, held_o, toggle_o
   );
endinterface

// File: rtl/btn_edge_detect.sv
// Samples the debounced level and derives rise/fall strobes.
// Build option: none (BTN_AUTOREPEAT_EN affects the top only).
module btn_edge_detect #(
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic btn_db,
   output logic rise,
   output logic fall
);

   logic lvl;
   logic lvl_r;
   logic lvl_q;

   assign lvl = ACTIVE_HIGH ? btn_db : ~btn_db;

   // Both stages reset "pressed" so a button held through reset is ignored.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lvl_r <= 1'b1;
         lvl_q <= 1'b1;
      end else begin
         lvl_r <= lvl;
         lvl_q <= lvl_r;
      end
   end

   assign rise = lvl_r & ~lvl_q;
   assign fall = ~lvl_r & lvl_q;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into press/release/short/long events.
// Build option: BTN_AUTOREPEAT_EN adds repeat pulses while long-held.
module button_press_classifier
   import btn_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic Clk,
   input  logic Reset_n,
   button_press_classifier_if.slave bus
);

   localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
   localparam int REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);
   localparam int CW       = $clog2(max2(LONG_CYC, REP_CYC) + 1);

   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
`endif

   btn_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic rise, fall;
   logic press_q, press_d;
   logic rel_q, rel_d;
   logic short_q, short_d;
   logic long_q, long_d;
   logic held_q, held_d;
   logic tog_q, tog_d;
`ifdef BTN_AUTOREPEAT_EN
   logic rep_q, rep_d;
`endif

   btn_edge_detect #(
      .ACTIVE_HIGH (ACTIVE_HIGH)
   ) u_edge (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .btn_db  (bus.btn_db),
      .rise    (rise),
      .fall    (fall)
   );

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

   // Next-state, counter and event decode; release beats long/repeat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      tog_d   = tog_q;
`ifdef BTN_AUTOREPEAT_EN
      rep_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d = IDLE;
               cnt_d   = '0;
               short_d = 1'b1;
               rel_d   = 1'b1;
               tog_d   = ~tog_q;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         LONG_HELD: begin
            if (fall) begin
               state_d = IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (cnt_q == REP_LAST) begin
               cnt_d = '0;
               rep_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d != IDLE);
   end

   // State, counter and registered outputs.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         held_q  <= 1'b0;
         tog_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         short_q <= short_d;
         long_q  <= long_d;
         held_q  <= held_d;
         tog_q   <= tog_d;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   // Registered repeat pulse.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) rep_q <= 1'b0;
      else          rep_q <= rep_d;
   end
   assign bus.repeat_o = rep_q;
`else
   assign bus.repeat_o = 1'b0;
`endif

   assign bus.press_o   = press_q;
   assign bus.release_o = rel_q;
   assign bus.short_o   = short_q;
   assign bus.long_o    = long_q;
   assign bus.held_o    = held_q;
   assign bus.toggle_o  = tog_q;

endmodule
